// File: rtl/seq_alu.sv
`default_nettype none
// seq_alu: registered ALU with a start/busy/done handshake, signed-overflow flag
// and a WIDTH-iteration shift-add multiplier.
module seq_alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       opc,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             inC,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] outW,
  output logic             zer,
  output logic             neg,
  output logic             ovf
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0]   a_reg;
  logic [2*WIDTH-1:0] acc;
  logic [SHW-1:0]     cnt;

  logic [WIDTH:0]     add_full;
  logic [WIDTH:0]     sub_full;
  logic [WIDTH:0]     mac;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   alu_res;
  logic [WIDTH-1:0]   res_val;
  logic               alu_ovf;
  logic               ovf_val;
  logic               accept;
  logic               mul_start;
  logic               mul_last;
  logic               load_res;

  // Subtraction as A + ~B + ~C so both ops share the carry-based overflow rule:
  // overflow = carry out of the MSB xor carry into it.
  assign add_full = {1'b0, inA} + {1'b0, inB} + {{WIDTH{1'b0}}, inC};
  assign sub_full = {1'b0, inA} + {1'b0, ~inB} + {{WIDTH{1'b0}}, ~inC};

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (opc)
      OP_ADD: begin
        alu_res = add_full[WIDTH-1:0];
        alu_ovf = add_full[WIDTH] ^ add_full[WIDTH-1] ^ inA[WIDTH-1] ^ inB[WIDTH-1];
      end
      OP_SUB: begin
        alu_res = sub_full[WIDTH-1:0];
        alu_ovf = sub_full[WIDTH] ^ sub_full[WIDTH-1] ^ inA[WIDTH-1] ^ ~inB[WIDTH-1];
      end
      OP_AND:  alu_res = inA & inB;
      OP_OR:   alu_res = inA | inB;
      OP_XOR:  alu_res = inA ^ inB;
      OP_SHL:  alu_res = inA << inB[SHW-1:0];
      OP_MUL:  alu_res = '0;
      default: alu_res = inB;
    endcase
  end

  // The low half of the accumulator starts as B and doubles as the multiplier
  // shift register; its LSB selects whether A is added into the upper half.
  assign mac      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_reg} : '0);
  assign acc_next = {mac, acc[WIDTH-1:1]};

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    mul_start  = 1'b0;
    mul_last   = 1'b0;
    case (state)
      S_MUL: begin
        mul_last = (cnt == CNT_LAST);
        if (mul_last) state_next = S_DONE;
      end
      default: begin
        if (start) begin
          accept = 1'b1;
          if (opc == OP_MUL) begin
            mul_start  = 1'b1;
            state_next = S_MUL;
          end else begin
            state_next = S_DONE;
          end
        end else begin
          state_next = S_IDLE;
        end
      end
    endcase
  end

  assign load_res = (accept && !mul_start) || mul_last;
  assign res_val  = mul_last ? acc_next[WIDTH-1:0] : alu_res;
  assign ovf_val  = mul_last ? (|acc_next[2*WIDTH-1:WIDTH]) : alu_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg <= '0;
      acc   <= '0;
      cnt   <= '0;
      outW  <= '0;
      zer   <= 1'b0;
      neg   <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      if (mul_start) begin
        a_reg <= inA;
        acc   <= {{WIDTH{1'b0}}, inB};
        cnt   <= '0;
      end else if (state == S_MUL) begin
        acc <= acc_next;
        cnt <= cnt + 1'b1;
      end
      if (load_res) begin
        outW <= res_val;
        zer  <= (res_val == '0);
        neg  <= res_val[WIDTH-1];
        ovf  <= ovf_val;
      end
    end
  end

  assign busy = (state == S_MUL);
  assign done = (state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// Bench for seq_alu: a 16-bit and an 8-bit instance share stimulus; results
// are checked through per-instance scoreboards, latencies in the issuing task.
module tb_seq_alu;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  opc;
  logic [15:0] a16;
  logic [15:0] b16;
  logic        c;

  logic        busy16, done16, zer16, neg16, ovf16;
  logic [15:0] outW16;
  logic        busy8, done8, zer8, neg8, ovf8;
  logic [7:0]  outW8;

  typedef struct packed {
    logic [15:0] out;
    logic        zer;
    logic        neg;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [2:0]  opc;
    logic [15:0] a;
    logic [15:0] b;
    logic        c;
    logic [15:0] out;
    logic        zer;
    logic        neg;
    logic        ovf;
  } vec_t;

  exp_t q16[$];
  exp_t q8[$];
  vec_t vt[15];
  int   n_vec;
  int   n_fail;

  seq_alu #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start), .opc(opc),
    .inA(a16), .inB(b16), .inC(c),
    .busy(busy16), .done(done16), .outW(outW16),
    .zer(zer16), .neg(neg16), .ovf(ovf16)
  );

  seq_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .opc(opc),
    .inA(a16[7:0]), .inB(b16[7:0]), .inC(c),
    .busy(busy8), .done(done8), .outW(outW8),
    .zer(zer8), .neg(neg8), .ovf(ovf8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t model(int w, logic [2:0] op, logic [15:0] ai, logic [15:0] bi, logic ci);
    logic [31:0] m, a, b, r, p;
    logic        ov;
    int          msb;
    exp_t        e;
    m   = (32'd1 << w) - 32'd1;
    a   = {16'd0, ai} & m;
    b   = {16'd0, bi} & m;
    msb = w - 1;
    ov  = 1'b0;
    case (op)
      3'd0: begin r = (a + b + {31'd0, ci}) & m; ov = (a[msb] == b[msb]) && (r[msb] != a[msb]); end
      3'd1: begin r = (a - b - {31'd0, ci}) & m; ov = (a[msb] != b[msb]) && (r[msb] != a[msb]); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = (a << (b & (w - 1))) & m;
      3'd6: begin p = a * b; r = p & m; ov = (p >> w) != 0; end
      default: r = b;
    endcase
    e.out = r[15:0];
    e.zer = (r == 0);
    e.neg = r[msb];
    e.ovf = ov;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done16) begin
      if (q16.size() == 0) chk("unexpected_done16", 32'd1, 32'd0);
      else begin
        e = q16.pop_front();
        chk("result16 {outW,zer,neg,ovf}", {13'd0, outW16, zer16, neg16, ovf16},
            {13'd0, e.out, e.zer, e.neg, e.ovf});
      end
    end
    if (rst_n && done8) begin
      if (q8.size() == 0) chk("unexpected_done8", 32'd1, 32'd0);
      else begin
        e = q8.pop_front();
        chk("result8 {outW,zer,neg,ovf}", {21'd0, outW8, zer8, neg8, ovf8},
            {21'd0, e.out[7:0], e.zer, e.neg, e.ovf});
      end
    end
  end

  // Called at a negedge; returns at the negedge where both instances show done.
  // poke>0 issues a stray ADD start k cycles into the operation.
  task automatic issue(logic [2:0] op, logic [15:0] a, logic [15:0] b, logic ci, exp_t e16, int poke);
    int          l16, l8, x16, x8;
    logic [15:0] prev;
    prev = outW16;
    x16  = (op == 3'b110) ? 17 : 1;
    x8   = (op == 3'b110) ? 9 : 1;
    opc = op; a16 = a; b16 = b; c = ci; start = 1'b1;
    q16.push_back(e16);
    q8.push_back(model(8, op, a, b, ci));
    @(posedge clk);
    l16 = 0;
    l8  = 0;
    for (int k = 1; k <= 40 && (l16 == 0 || l8 == 0); k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        opc = 3'($urandom); a16 = 16'($urandom); b16 = 16'($urandom); c = 1'($urandom);
      end
      if (poke > 0 && k == poke) begin
        opc = 3'b000; a16 = 16'h1111; b16 = 16'h2222; start = 1'b1;
      end
      if (poke > 0 && k == poke + 1) start = 1'b0;
      if (done16 && l16 == 0) l16 = k;
      if (done8 && l8 == 0) l8 = k;
      if (op == 3'b110 && k == 16) begin
        chk("busy16_last_mul_cycle", {31'd0, busy16}, 32'd1);
        chk("outW16_held_during_mul", {16'd0, outW16}, {16'd0, prev});
      end
    end
    chk("latency16", l16, x16);
    chk("latency8", l8, x8);
  endtask

  initial begin
    exp_t e;
    int   cnt_done;
    n_vec = 0;
    n_fail = 0;
    vt[0]  = '{3'd0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1};
    vt[1]  = '{3'd1, 16'h0005, 16'h0004, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0};
    vt[2]  = '{3'd6, 16'h0012, 16'h0034, 1'b0, 16'h03A8, 1'b0, 1'b0, 1'b0};
    vt[3]  = '{3'd6, 16'h0100, 16'h0100, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vt[4]  = '{3'd2, 16'hF0F0, 16'h3C3C, 1'b1, 16'h3030, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{3'd3, 16'hF0F0, 16'h0F0F, 1'b0, 16'hFFFF, 1'b0, 1'b1, 1'b0};
    vt[6]  = '{3'd4, 16'hAAAA, 16'hAAAA, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
    vt[7]  = '{3'd5, 16'h0001, 16'h0013, 1'b0, 16'h0008, 1'b0, 1'b0, 1'b0};
    vt[8]  = '{3'd7, 16'h1234, 16'h8001, 1'b1, 16'h8001, 1'b0, 1'b1, 1'b0};
    vt[9]  = '{3'd1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b1};
    vt[10] = '{3'd0, 16'hFFFF, 16'h0001, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0};
    vt[11] = '{3'd6, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b1};
    vt[12] = '{3'd5, 16'h8001, 16'h000F, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vt[13] = '{3'd0, 16'h0001, 16'h0002, 1'b1, 16'h0004, 1'b0, 1'b0, 1'b0};
    vt[14] = '{3'd1, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b0, 1'b1, 1'b0};

    rst_n = 1'b0;
    start = 1'($urandom);
    opc = 3'($urandom); a16 = 16'($urandom); b16 = 16'($urandom); c = 1'($urandom);
    #2;
    chk("reset_async16", {24'd0, busy16, done16, zer16, neg16, ovf16, 3'd0} | {16'd0, outW16}, 32'd0);
    @(negedge clk);
    chk("reset_held8", {24'd0, busy8, done8, zer8, neg8, ovf8, 3'd0} | {24'd0, outW8}, 32'd0);
    start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("idle_after_release", {30'd0, busy16, done16}, 32'd0);

    for (int i = 0; i < 15; i++) begin
      e.out = vt[i].out; e.zer = vt[i].zer; e.neg = vt[i].neg; e.ovf = vt[i].ovf;
      issue(vt[i].opc, vt[i].a, vt[i].b, vt[i].c, e, 0);
    end

    // Stray ADD while the multiplier is on iteration 3 must be dropped.
    issue(3'd6, 16'h0012, 16'h0034, 1'b0, exp_t'({16'h03A8, 1'b0, 1'b0, 1'b0}), 3);
    @(posedge clk);
    @(negedge clk);
    chk("no_done_after_ignored_start", {31'd0, done16}, 32'd0);

    issue(3'd0, 16'h1000, 16'h0234, 1'b0, model(16, 3'd0, 16'h1000, 16'h0234, 1'b0), 0);
    issue(3'd4, 16'h00FF, 16'h0F0F, 1'b0, model(16, 3'd4, 16'h00FF, 16'h0F0F, 1'b0), 0);
    issue(3'd5, 16'h0003, 16'h0004, 1'b0, exp_t'({16'h0030, 1'b0, 1'b0, 1'b0}), 0);
    issue(3'd7, 16'h0000, 16'h1234, 1'b0, exp_t'({16'h1234, 1'b0, 1'b0, 1'b0}), 0);
    @(posedge clk);
    @(negedge clk);
    chk("done_low_after_burst", {31'd0, done16}, 32'd0);

    // Asynchronous reset on multiply iteration 5 aborts without a done.
    opc = 3'd6; a16 = 16'h1234; b16 = 16'h5678; start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("abort_reset16", {24'd0, busy16, done16, zer16, neg16, ovf16, 3'd0} | {16'd0, outW16}, 32'd0);
    chk("abort_reset8", {24'd0, busy8, done8, zer8, neg8, ovf8, 3'd0} | {24'd0, outW8}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt_done = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done16 || done8 || busy16) cnt_done++;
    end
    chk("no_activity_after_abort", cnt_done, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    issue(3'd0, 16'h0001, 16'h0002, 1'b0, exp_t'({16'h0003, 1'b0, 1'b0, 1'b0}), 0);

    for (int i = 0; i < 1000; i++) begin
      logic [2:0]  rop;
      logic [15:0] ra, rb;
      logic        rc;
      rop = 3'($urandom_range(0, 7));
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rc  = 1'($urandom);
      issue(rop, ra, rb, rc, model(16, rop, ra, rb, rc), 0);
    end

    @(negedge clk);
    chk("queue16_drained", q16.size(), 0);
    chk("queue8_drained", q8.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
